// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus Mini-SRC-style datapath.
// There is no control unit in this block. Every register enable, bus driver,
// ALU operation and memory strobe comes in on a port. The block holds the
// register file, the special registers, the ALU, the CON flip-flop, the RAM
// and the IN/OUT ports, all connected by one shared 32-bit bus.
module cpu_datapath #(
  parameter int MEM_DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        IRout,
  input  logic        MDRout,
  input  logic        INout,
  input  logic        Cout,
  input  logic        Yout,
  input  logic        MARout,
  input  logic        Read,
  input  logic        IncPC,
  input  logic        AND,
  input  logic        OR,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        MUL,
  input  logic        DIV,
  input  logic        SHR,
  input  logic        SHRA,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Zin,
  input  logic        Yin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        CONin,
  input  logic        OUT_Portin,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        CON_RESET,
  input  logic [31:0] IN_unit_input,
  output logic [31:0] OUT_unit_output
);

  localparam int AW = $clog2(MEM_DEPTH);

  // Which source currently owns the bus, after priority resolution.
  typedef enum logic [3:0] {
    SRC_NONE, SRC_REG, SRC_BA_ZERO, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO,
    SRC_PC, SRC_MDR, SRC_IN, SRC_C, SRC_Y, SRC_MAR, SRC_IR
  } bus_src_e;

  // ALU operation after priority resolution; OP_PASS forwards the bus.
  typedef enum logic [3:0] {
    OP_PASS, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR,
    OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT
  } alu_op_e;

  // Architectural state
  logic [31:0]   regs [16];
  logic [31:0]   pc;
  logic [31:0]   ir;
  logic [AW-1:0] mar;
  logic [31:0]   mdr;
  logic [31:0]   y;
  logic [63:0]   z;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          con;
  logic [31:0]   mem [MEM_DEPTH];

  // Combinational nets
  logic [31:0] bus;
  bus_src_e    bus_src;
  logic [3:0]  sel_idx;
  logic        sel_valid;
  logic [31:0] c_sext;
  logic [31:0] mem_rdata;
  alu_op_e     alu_op;
  logic [63:0] alu_result;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [4:0]  shamt;
  logic [31:0] shr_res, shra_res, shl_res, ror_res, rol_res;
  logic        con_cond;

  // RAM reads are combinational, so read_mem carries no information here.
  logic unused_read_mem;
  assign unused_read_mem = read_mem;

  // Sign-extended constant field and asynchronous RAM read.
  assign c_sext    = {{13{ir[18]}}, ir[18:0]};
  assign mem_rdata = mem[mar];

  // Register-field select: Ra beats Rb beats Rc.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    sel_idx   = 4'd0;
    sel_valid = 1'b1;
    if (Gra)      sel_idx = ir[26:23];
    else if (Grb) sel_idx = ir[22:19];
    else if (Grc) sel_idx = ir[18:15];
    else          sel_valid = 1'b0;
  end

  // Bus driver priority; IncPC alone puts PC on the bus for the fetch step.
  always_comb begin
    bus_src = SRC_NONE;
    if ((Rout || BAout) && sel_valid)
      bus_src = (BAout && sel_idx == 4'd0) ? SRC_BA_ZERO : SRC_REG;
    else if (HIout)    bus_src = SRC_HI;
    else if (LOout)    bus_src = SRC_LO;
    else if (Zhighout) bus_src = SRC_ZHI;
    else if (Zlowout)  bus_src = SRC_ZLO;
    else if (PCout)    bus_src = SRC_PC;
    else if (MDRout)   bus_src = SRC_MDR;
    else if (INout)    bus_src = SRC_IN;
    else if (Cout)     bus_src = SRC_C;
    else if (Yout)     bus_src = SRC_Y;
    else if (MARout)   bus_src = SRC_MAR;
    else if (IRout)    bus_src = SRC_IR;
    else if (IncPC)    bus_src = SRC_PC;
  end

  // Bus multiplexer; an undriven bus reads as zero.
  always_comb begin
    case (bus_src)
      SRC_REG: bus = regs[sel_idx];
      SRC_HI:  bus = hi;
      SRC_LO:  bus = lo;
      SRC_ZHI: bus = z[63:32];
      SRC_ZLO: bus = z[31:0];
      SRC_PC:  bus = pc;
      SRC_MDR: bus = mdr;
      SRC_IN:  bus = IN_unit_input;
      SRC_C:   bus = c_sext;
      SRC_Y:   bus = y;
      SRC_MAR: bus = {{(32 - AW){1'b0}}, mar};
      SRC_IR:  bus = ir;
      default: bus = '0;
    endcase
  end

  // ALU operation priority follows the strobe order on the port list.
  always_comb begin
    alu_op = OP_PASS;
    if (AND)       alu_op = OP_AND;
    else if (OR)   alu_op = OP_OR;
    else if (ADD)  alu_op = OP_ADD;
    else if (SUB)  alu_op = OP_SUB;
    else if (MUL)  alu_op = OP_MUL;
    else if (DIV)  alu_op = OP_DIV;
    else if (SHR)  alu_op = OP_SHR;
    else if (SHRA) alu_op = OP_SHRA;
    else if (SHL)  alu_op = OP_SHL;
    else if (ROR)  alu_op = OP_ROR;
    else if (ROL)  alu_op = OP_ROL;
    else if (NEG)  alu_op = OP_NEG;
    else if (NOT)  alu_op = OP_NOT;
  end

  // Signed multiply: the low 64 bits of the product of the sign-extended
  // operands equal the signed 32x32 product.
  assign product = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};

  // Signed divide; x/0 yields 0, and INT_MIN/-1 wraps to INT_MIN rem 0.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (bus != '0) begin
      if (y == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
        quotient = 32'h8000_0000;
      end else begin
        quotient  = $signed(y) / $signed(bus);
        remainder = $signed(y) % $signed(bus);
      end
    end
  end

  // Shifts and rotates of A (Y) by B[4:0]; a shift by 32 gives 0, which
  // makes the rotate-by-zero case come out right.
  assign shamt    = bus[4:0];
  assign shr_res  = y >> shamt;
  assign shra_res = $signed(y) >>> shamt;
  assign shl_res  = y << shamt;
  assign ror_res  = (y >> shamt) | (y << (6'd32 - {1'b0, shamt}));
  assign rol_res  = (y << shamt) | (y >> (6'd32 - {1'b0, shamt}));

  // ALU result into Z: 32-bit operations zero the upper half.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_result = {32'b0, y & bus};
      OP_OR:   alu_result = {32'b0, y | bus};
      OP_ADD:  alu_result = {32'b0, y + bus};
      OP_SUB:  alu_result = {32'b0, y - bus};
      OP_MUL:  alu_result = product;
      OP_DIV:  alu_result = {remainder, quotient};
      OP_SHR:  alu_result = {32'b0, shr_res};
      OP_SHRA: alu_result = {32'b0, shra_res};
      OP_SHL:  alu_result = {32'b0, shl_res};
      OP_ROR:  alu_result = {32'b0, ror_res};
      OP_ROL:  alu_result = {32'b0, rol_res};
      OP_NEG:  alu_result = {32'b0, 32'd0 - bus};
      OP_NOT:  alu_result = {32'b0, ~bus};
      default: alu_result = {32'b0, bus};
    endcase
  end

  // Branch condition of the bus value, chosen by the C2 field.
  always_comb begin
    case (ir[20:19])
      2'b00:   con_cond = (bus == '0);
      2'b01:   con_cond = (bus != '0);
      2'b10:   con_cond = ~bus[31];
      default: con_cond = bus[31];
    endcase
  end

  // General register file: the selected register loads the bus on Rin.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the bus as it was before the edge, whatever the block order.
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (Rin && sel_valid) begin
      regs[sel_idx] <= bus;
    end
  end

  // Program counter: increment on IncPC, otherwise load from the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pc <= '0;
    else if (PCin) pc <= IncPC ? pc + 32'd1 : bus;
  end

  // IR, MAR, MDR and Y; MDR takes RAM data when Read is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
    end else begin
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus[AW-1:0];
      if (MDRin) mdr <= Read ? mem_rdata : bus;
      if (Yin)   y   <= bus;
    end
  end

  // Z, HI and LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z  <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (Zin)  z  <= alu_result;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
    end
  end

  // CON flip-flop: the synchronous clear wins over a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         con <= 1'b0;
    else if (CON_RESET) con <= 1'b0;
    else if (CONin)     con <= con_cond;
  end

  // OUT port register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          OUT_unit_output <= '0;
    else if (OUT_Portin) OUT_unit_output <= bus;
  end

  // RAM write port: MDR is written to RAM[MAR] on the edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset, so a program stored before reset stays put.
    if (write_mem) mem[mar] <= mdr;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed tests for cpu_datapath. Control words are applied
// one cycle at a time; state is observed #1 after the rising edge.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout;
  logic        Cout, Yout, MARout, Read, IncPC;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic        read_mem, write_mem, CON_RESET;
  logic [31:0] IN_unit_input;
  logic [31:0] OUT_unit_output;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } alu_vec_t;

  cpu_datapath #(.MEM_DEPTH(512)) dut (
    .clk(clk), .reset(reset),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout),
    .Cout(Cout), .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
    .read_mem(read_mem), .write_mem(write_mem), .CON_RESET(CON_RESET),
    .IN_unit_input(IN_unit_input), .OUT_unit_output(OUT_unit_output)
  );

  always #5 clk = ~clk;

  task automatic idle();
    {HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout} = '0;
    {Cout, Yout, MARout, Read, IncPC} = '0;
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin} = '0;
    {read_mem, write_mem, CON_RESET} = '0;
    IN_unit_input = '0;
  endtask

  // Apply the current control word for one rising edge, then clear it.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    IN_unit_input = v; INout = 1; IRin = 1; tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    IN_unit_input = v; INout = 1; Yin = 1; tick();
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
    load_ir({5'b0, idx, 23'b0});
    IN_unit_input = v; INout = 1; Gra = 1; Rin = 1; tick();
  endtask

  task automatic write_ram(input logic [31:0] addr, input logic [31:0] data);
    IN_unit_input = addr; INout = 1; MARin = 1; tick();
    IN_unit_input = data; INout = 1; MDRin = 1; tick();
    write_mem = 1; tick();
  endtask

  // T0..T2: instruction fetch from RAM[PC].
  task automatic run_fetch();
    IncPC = 1; MARin = 1; PCin = 1; Read = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
  endtask

  // T3..T5: ldi execute, Ra <- C + (Rb or 0).
  task automatic run_ldi_exec();
    Grb = 1; BAout = 1; Yin = 1; tick();
    Cout = 1; ADD = 1; Zin = 1; tick();
    Zlowout = 1; Gra = 1; Rin = 1; tick();
  endtask

  task automatic set_op(input int op);
    case (op)
      0:  AND = 1;
      1:  OR = 1;
      2:  ADD = 1;
      3:  SUB = 1;
      4:  MUL = 1;
      5:  DIV = 1;
      6:  SHR = 1;
      7:  SHRA = 1;
      8:  SHL = 1;
      9:  ROR = 1;
      10: ROL = 1;
      11: NEG = 1;
      12: NOT = 1;
      14: begin AND = 1; ADD = 1; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    tests_run++;
    if (dut.pc !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", dut.pc, 32'd0); end
    tests_run++;
    if ({dut.ir, dut.mdr, dut.y} !== 96'd0) begin tests_failed++; $display("FAIL reset_ir_mdr_y: got %h want 0", {dut.ir, dut.mdr, dut.y}); end
    tests_run++;
    if ({dut.z, dut.hi, dut.lo} !== 128'd0) begin tests_failed++; $display("FAIL reset_z_hi_lo: got %h want 0", {dut.z, dut.hi, dut.lo}); end
    tests_run++;
    if ({dut.con, OUT_unit_output} !== 33'd0) begin tests_failed++; $display("FAIL reset_con_out: got %h want 0", {dut.con, OUT_unit_output}); end
    reset = 1'b1;
  endtask

  task automatic test_ldi();
    write_ram(32'd0, 32'h0980_0065);
    do_reset();
    IncPC = 1; MARin = 1; PCin = 1; Read = 1; tick();
    tests_run++;
    if (dut.pc !== 32'd1 || dut.mar !== 9'd0) begin tests_failed++; $display("FAIL ldi_t0: got pc=%h mar=%h want pc=1 mar=0", dut.pc, dut.mar); end
    Read = 1; MDRin = 1; tick();
    tests_run++;
    if (dut.mdr !== 32'h0980_0065) begin tests_failed++; $display("FAIL ldi_mdr: got %h want %h", dut.mdr, 32'h0980_0065); end
    MDRout = 1; IRin = 1; tick();
    tests_run++;
    if (dut.ir !== 32'h0980_0065) begin tests_failed++; $display("FAIL ldi_ir: got %h want %h", dut.ir, 32'h0980_0065); end
    run_ldi_exec();
    tests_run++;
    if (dut.y !== 32'd0) begin tests_failed++; $display("FAIL ldi_y: got %h want 0", dut.y); end
    tests_run++;
    if (dut.regs[3] !== 32'h65) begin tests_failed++; $display("FAIL ldi_r3: got %h want %h", dut.regs[3], 32'h65); end
    Gra = 1; Rout = 1; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'h65) begin tests_failed++; $display("FAIL ldi_out_r3: got %h want %h", OUT_unit_output, 32'h65); end
    // Second fetch step: MAR takes the old PC while PC increments.
    IncPC = 1; MARin = 1; PCin = 1; tick();
    tests_run++;
    if (dut.pc !== 32'd2 || dut.mar !== 9'd1) begin tests_failed++; $display("FAIL ldi_old_pc: got pc=%h mar=%h want pc=2 mar=1", dut.pc, dut.mar); end
  endtask

  task automatic test_ldi_indexed();
    write_ram(32'd0, 32'h0990_0065);
    do_reset();
    set_reg(4'd2, 32'h10);
    run_fetch();
    run_ldi_exec();
    tests_run++;
    if (dut.y !== 32'h10) begin tests_failed++; $display("FAIL ldix_y: got %h want %h", dut.y, 32'h10); end
    tests_run++;
    if (dut.regs[3] !== 32'h75) begin tests_failed++; $display("FAIL ldix_r3: got %h want %h", dut.regs[3], 32'h75); end
  endtask

  task automatic test_baout_r0();
    write_ram(32'd0, 32'h0A80_0005);
    do_reset();
    set_reg(4'd0, 32'h1234);
    Gra = 1; Rout = 1; #1;
    tests_run++;
    if (dut.bus !== 32'h1234) begin tests_failed++; $display("FAIL rout_r0: got %h want %h", dut.bus, 32'h1234); end
    idle(); Gra = 1; BAout = 1; #1;
    tests_run++;
    if (dut.bus !== 32'd0) begin tests_failed++; $display("FAIL baout_r0: got %h want 0", dut.bus); end
    idle();
    run_fetch();
    run_ldi_exec();
    tests_run++;
    if (dut.y !== 32'd0) begin tests_failed++; $display("FAIL ba_y: got %h want 0", dut.y); end
    tests_run++;
    if (dut.regs[5] !== 32'd5 || dut.regs[0] !== 32'h1234) begin tests_failed++; $display("FAIL ba_r5: got r5=%h r0=%h want r5=5 r0=1234", dut.regs[5], dut.regs[0]); end
  endtask

  task automatic test_neg_const();
    load_ir(32'h0007_FFFF);
    load_y(32'h10);
    Cout = 1; #1;
    tests_run++;
    if (dut.bus !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL cout_sext: got %h want %h", dut.bus, 32'hFFFF_FFFF); end
    ADD = 1; Zin = 1; tick();
    tests_run++;
    if (dut.z !== 64'h0000_0000_0000_000F) begin tests_failed++; $display("FAIL neg_const_z: got %h want %h", dut.z, 64'hF); end
  endtask

  task automatic test_mul_div();
    load_y(32'hFFFF_FFFD);
    IN_unit_input = 32'd7; INout = 1; MUL = 1; Zin = 1; tick();
    tests_run++;
    if (dut.z !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL mul_z: got %h want %h", dut.z, 64'hFFFF_FFFF_FFFF_FFEB); end
    load_y(32'd17);
    IN_unit_input = 32'd5; INout = 1; DIV = 1; Zin = 1; tick();
    Zhighout = 1; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'd2) begin tests_failed++; $display("FAIL div_zhigh: got %h want 2", OUT_unit_output); end
    Zlowout = 1; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'd3) begin tests_failed++; $display("FAIL div_zlow: got %h want 3", OUT_unit_output); end
    IN_unit_input = 32'd0; INout = 1; DIV = 1; Zin = 1; tick();
    tests_run++;
    if (dut.z !== 64'd0) begin tests_failed++; $display("FAIL div_zero: got %h want 0", dut.z); end
  endtask

  task automatic test_alu_ops();
    alu_vec_t vecs [15];
    vecs = '{
      '{0,  32'hF0F0_1234, 32'h0FF0_FFFF, 64'h0000_0000_00F0_1234},
      '{1,  32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F},
      '{2,  32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_0000_0001},
      '{3,  32'h0000_0005, 32'h0000_0007, 64'h0000_0000_FFFF_FFFE},
      '{5,  32'hFFFF_FFEF, 32'h0000_0005, 64'hFFFF_FFFE_FFFF_FFFD},
      '{6,  32'h8000_0000, 32'h0000_0004, 64'h0000_0000_0800_0000},
      '{7,  32'h8000_0000, 32'h0000_0004, 64'h0000_0000_F800_0000},
      '{8,  32'h0000_0001, 32'h0000_0024, 64'h0000_0000_0000_0010},
      '{9,  32'h0000_0001, 32'h0000_0001, 64'h0000_0000_8000_0000},
      '{10, 32'h8000_0001, 32'h0000_0001, 64'h0000_0000_0000_0003},
      '{9,  32'h1234_5678, 32'h0000_0000, 64'h0000_0000_1234_5678},
      '{11, 32'h0000_0000, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF},
      '{12, 32'h0000_0000, 32'h0F0F_0000, 64'h0000_0000_F0F0_FFFF},
      '{13, 32'h0000_0009, 32'h1234_5678, 64'h0000_0000_1234_5678},
      '{14, 32'h0000_0006, 32'h0000_0003, 64'h0000_0000_0000_0002}
    };
    for (int i = 0; i < 15; i++) begin
      load_y(vecs[i].a);
      IN_unit_input = vecs[i].b; INout = 1; set_op(vecs[i].op); Zin = 1; tick();
      tests_run++;
      if (dut.z !== vecs[i].z) begin
        tests_failed++;
        $display("FAIL alu_vec%0d op%0d: got %h want %h", i, vecs[i].op, dut.z, vecs[i].z);
      end
    end
  endtask

  task automatic test_con();
    load_ir(32'h0018_0000);
    IN_unit_input = 32'h8000_0000; INout = 1; CONin = 1; tick();
    tests_run++;
    if (dut.con !== 1'b1) begin tests_failed++; $display("FAIL con_lt0: got %b want 1", dut.con); end
    load_ir(32'h0010_0000);
    IN_unit_input = 32'h8000_0000; INout = 1; CONin = 1; tick();
    tests_run++;
    if (dut.con !== 1'b0) begin tests_failed++; $display("FAIL con_ge0: got %b want 0", dut.con); end
    load_ir(32'h0008_0000);
    IN_unit_input = 32'd5; INout = 1; CONin = 1; tick();
    tests_run++;
    if (dut.con !== 1'b1) begin tests_failed++; $display("FAIL con_ne0: got %b want 1", dut.con); end
    load_ir(32'h0000_0000);
    CONin = 1; CON_RESET = 1; tick();
    tests_run++;
    if (dut.con !== 1'b0) begin tests_failed++; $display("FAIL con_reset_wins: got %b want 0", dut.con); end
    CONin = 1; tick();
    tests_run++;
    if (dut.con !== 1'b1) begin tests_failed++; $display("FAIL con_eq0: got %b want 1", dut.con); end
  endtask

  task automatic test_bus_priority();
    IN_unit_input = 32'hAAAA_5555; INout = 1; HIin = 1; tick();
    IN_unit_input = 32'h0000_1357; INout = 1; LOin = 1; tick();
    HIout = 1; LOout = 1; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL prio_hi_lo: got %h want %h", OUT_unit_output, 32'hAAAA_5555); end
    LOout = 1; INout = 1; IN_unit_input = 32'hDEAD_BEEF; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'h0000_1357) begin tests_failed++; $display("FAIL prio_lo_in: got %h want %h", OUT_unit_output, 32'h1357); end
    IN_unit_input = 32'hFFFF_FFFF; INout = 1; MARin = 1; tick();
    MARout = 1; OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'h0000_01FF) begin tests_failed++; $display("FAIL marout_zext: got %h want %h", OUT_unit_output, 32'h1FF); end
    OUT_Portin = 1; tick();
    tests_run++;
    if (OUT_unit_output !== 32'd0) begin tests_failed++; $display("FAIL idle_bus: got %h want 0", OUT_unit_output); end
  endtask

  task automatic test_async_reset();
    write_ram(32'd0, 32'h0980_0065);
    do_reset();
    run_fetch();
    run_ldi_exec();
    tests_run++;
    if (dut.regs[3] !== 32'h65 || dut.pc !== 32'd1) begin tests_failed++; $display("FAIL areset_pre: got r3=%h pc=%h want r3=65 pc=1", dut.regs[3], dut.pc); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (dut.regs[3] !== 32'd0 || dut.pc !== 32'd0) begin tests_failed++; $display("FAIL areset_r3_pc: got r3=%h pc=%h want 0", dut.regs[3], dut.pc); end
    tests_run++;
    if ({dut.ir, dut.y, dut.mdr, dut.z} !== 160'd0) begin tests_failed++; $display("FAIL areset_ir_y_mdr_z: got %h want 0", {dut.ir, dut.y, dut.mdr, dut.z}); end
    tests_run++;
    if (dut.mem[0] !== 32'h0980_0065) begin tests_failed++; $display("FAIL areset_ram_kept: got %h want %h", dut.mem[0], 32'h0980_0065); end
    reset = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_ldi();
    test_ldi_indexed();
    test_baout_r0();
    test_neg_const();
    test_mul_div();
    test_alu_ops();
    test_con();
    test_bus_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
